seq_divider16: RTL and testbench

- Sequential restoring unsigned divider. It is the inverse of the ripple adder/subtractor chain: it computes quotient and remainder by shift-and-subtract, one bit per clock.
- Sits beside the 16-bit adder/subtractor in the arithmetic datapath.
- Uses a start/busy/done handshake so a controller can launch one division and wait for it.

---
 rtl/seq_divider16.sv | 143 ++++++++++++++
 tb/tb_seq_divider16.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider16.sv
// rtl/seq_divider16.sv - sequential restoring unsigned divider, one quotient bit per clock
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   start        launch request, sampled only while idle
//   dividend     unsigned dividend, captured on the accepted start edge
//   divisor      unsigned divisor, captured on the accepted start edge
//   busy         high while a division is in flight
//   done         one-cycle pulse when quotient/remainder become valid
//   quotient     unsigned quotient (all ones on divide-by-zero)
//   remainder    unsigned remainder (dividend on divide-by-zero)
//   div_by_zero  set with done when the captured divisor was zero

module seq_divider16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_d;
    // Holds the dividend as it shifts out MSB-first while quotient bits shift in at the LSB.
    logic [WIDTH-1:0] r_q;
    // Partial remainder. It never exceeds the divisor, so WIDTH bits suffice to store it;
    // the extra bit needed for the trial subtraction lives only in the combinational path.
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_count;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;

    // Bring the next dividend bit into the partial remainder and try subtracting the divisor.
    // A clear MSB on the (WIDTH+1)-bit difference means the divisor fit.
    assign w_shift = {r_rem, r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_d};
    assign w_fits  = ~w_trial[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_d           <= '0;
            r_q           <= '0;
            r_rem         <= '0;
            r_count       <= '0;
            r_zero        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_d    <= divisor;
                        r_q    <= dividend;
                        r_rem  <= '0;
                        if (divisor == '0) begin
                            // No iterations: go straight to reporting the zero-divisor result.
                            r_zero  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_zero        <= 1'b0;
                            r_div_by_zero <= 1'b0;
                            r_count       <= CW'(WIDTH - 1);
                            r_state       <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    if (w_fits) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        // Divisor did not fit: keep the shifted value (restore), whose top bit is 0.
                        r_rem <= w_shift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    if (r_count == '0) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end

                S_FINISH: begin
                    if (r_zero) begin
                        r_quotient    <= '1;
                        r_remainder   <= r_q;
                        r_div_by_zero <= 1'b1;
                    end else begin
                        r_quotient    <= r_q;
                        r_remainder   <= r_rem;
                        r_div_by_zero <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider16.sv
// tb/tb_seq_divider16.sv - scoreboard testbench for seq_divider16

module tb_seq_divider16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider16 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           s_edge;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference: plain integer division, with the fixed zero-divisor convention.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int s);
        exp_t e;
        e.a      = a;
        e.b      = b;
        e.z      = (b == 0);
        e.q      = e.z ? {W{1'b1}} : W'(a / b);
        e.r      = e.z ? a : W'(a % b);
        e.s_edge = s;
        e.lat    = e.z ? 1 : W + 1;
        return e;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (done) begin
                chk("done_width", {31'b0, prev_done}, 32'd0);
                chk("busy_with_done", {31'b0, busy}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (edge %0d)", edge_n);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", {16'b0, quotient}, {16'b0, e.q});
                    chk("remainder", {16'b0, remainder}, {16'b0, e.r});
                    chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
                    chk("latency", edge_n - e.s_edge, e.lat);
                    if (!e.z) begin
                        chk("invariant", {16'b0, quotient} * {16'b0, e.b} + {16'b0, remainder},
                            {16'b0, e.a});
                        chk("rem_lt_div", {31'b0, (remainder < e.b)}, 32'd1);
                    end
                end
            end
            prev_done = done;
        end
    end

    // Drives a start pulse at a falling edge; s is the index of the edge that samples it.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push, output int s);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        s        = edge_n + 1;
        if (push) sb.push_back(model(a, b, s));
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Leaves us one falling edge before the done cycle so the next issue lands in it.
    task automatic wait_done_cycle(input int s, input int lat);
        while (edge_n < s + lat - 1) @(negedge clk);
    endtask

    initial begin
        int s;
        int s2;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_quotient", {16'b0, quotient}, 0);
        chk("rst_remainder", {16'b0, remainder}, 0);
        chk("rst_dbz", {31'b0, div_by_zero}, 0);
        rst = 1'b0;

        // 100 / 7 with busy window check
        issue(16'd100, 16'd7, 1'b1, s);
        for (int k = 1; k <= W; k++) begin
            while (edge_n < s + k) @(negedge clk);
            chk("busy_window", {31'b0, busy}, 1);
        end
        wait_done_cycle(s, W + 1);

        // Back-to-back directed cases
        issue(16'hFFFF, 16'd1, 1'b1, s);
        wait_done_cycle(s, W + 1);
        issue(16'hFFFF, 16'hFFFF, 1'b1, s);
        wait_done_cycle(s, W + 1);
        issue(16'd3, 16'd10, 1'b1, s);
        wait_done_cycle(s, W + 1);
        issue(16'd0, 16'd9, 1'b1, s);
        wait_done_cycle(s, W + 1);

        // Zero divisor
        issue(16'd5, 16'd0, 1'b1, s);
        while (edge_n < s + 2) @(negedge clk);
        chk("busy_after_dbz", {31'b0, busy}, 0);

        // Start during busy is ignored; start in the done cycle is accepted
        issue(16'd1000, 16'd9, 1'b1, s);
        while (edge_n < s + 4) @(negedge clk);
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done_cycle(s, W + 1);
        issue(16'd50, 16'd5, 1'b1, s);
        wait_done_cycle(s, W + 1);
        repeat (2) @(negedge clk);

        // Reset in the middle of CALC discards the operation
        issue(16'd1234, 16'd5, 1'b1, s);
        while (edge_n < s + 7) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_done", {31'b0, done}, 0);
        chk("midrst_quotient", {16'b0, quotient}, 0);
        chk("midrst_remainder", {16'b0, remainder}, 0);
        chk("midrst_dbz", {31'b0, div_by_zero}, 0);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        issue(16'd1234, 16'd5, 1'b1, s);
        wait_done_cycle(s, W + 1);

        // Randomized operands, back-to-back, with occasional ignored mid-flight starts
        for (int n = 0; n < 200; n++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 16'd1;
                2:       b = W'($urandom_range(1, 15));
                3:       b = a;
                4:       begin a = W'($urandom_range(0, 20)); b = W'($urandom_range(21, 1000)); end
                default: b = W'($urandom);
            endcase
            issue(a, b, 1'b1, s);
            if (b != 0 && $urandom_range(0, 3) == 0) begin
                issue(W'($urandom), W'($urandom), 1'b0, s2);
            end
            wait_done_cycle(s, (b == 0) ? 1 : W + 1);
        end

        // Drain: bounded wait for the last result
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
